// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, write-allocate data cache with one-word lines.
// Read hits return data in the same cycle; misses and all writes stall until memory acks.
module dcache_wt #(
  parameter int unsigned LINES = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      w_data_i,
  output logic [31:0]      r_data_o,
  output logic             stall_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_ack_i,
  output logic [CNT_W-1:0] rd_hit_cnt_o,
  output logic [CNT_W-1:0] rd_miss_cnt_o
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = 30 - IdxW;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StWrWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Line storage: only the valid bits are reset.
  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Latched request (word address), store data and read response.
  logic [29:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      resp_q, resp_d;
  logic             resp_rd_q, resp_rd_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Single line write port shared by write-allocate and miss fill.
  logic            line_we;
  logic [IdxW-1:0] line_idx;
  logic [TagW-1:0] line_tag;
  logic [31:0]     line_data;

  logic [IdxW-1:0] req_idx;
  logic [TagW-1:0] req_tag;
  logic            hit;
  logic            unused_addr;

  assign req_idx     = addr_i[2 +: IdxW];
  assign req_tag     = addr_i[31 -: TagW];
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_d     = resp_q;
    resp_rd_d  = resp_rd_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    line_we    = 1'b0;
    line_idx   = req_idx;
    line_tag   = req_tag;
    line_data  = w_data_i;
    stall_o    = 1'b0;
    r_data_o   = '0;

    unique case (state_q)
      StIdle: begin
        if (MemWrite_i) begin
          // Stores win over loads and allocate the line immediately.
          stall_o   = 1'b1;
          addr_d    = addr_i[31:2];
          wdata_d   = w_data_i;
          resp_rd_d = 1'b0;
          line_we   = 1'b1;
          state_d   = StWrWait;
        end else if (MemRead_i && hit) begin
          r_data_o  = data_q[req_idx];
          hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end else if (MemRead_i) begin
          stall_o    = 1'b1;
          addr_d     = addr_i[31:2];
          miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d    = StRdWait;
        end
      end

      StRdWait: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          line_we   = 1'b1;
          line_idx  = addr_q[IdxW-1:0];
          line_tag  = addr_q[29 -: TagW];
          line_data = mem_rdata_i;
          resp_d    = mem_rdata_i;
          resp_rd_d = 1'b1;
          state_d   = StResp;
        end
      end

      StWrWait: begin
        stall_o = 1'b1;
        if (mem_ack_i) begin
          resp_rd_d = 1'b0;
          state_d   = StResp;
        end
      end

      StResp: begin
        // The still-present CPU request is the one just served; drop it.
        if (resp_rd_q) begin
          r_data_o = resp_q;
        end
        state_d = StIdle;
      end
    endcase
  end

  assign mem_req_o   = (state_q == StRdWait) || (state_q == StWrWait);
  assign mem_we_o    = (state_q == StWrWait);
  assign mem_addr_o  = mem_req_o ? {addr_q, 2'b00} : '0;
  assign mem_wdata_o = mem_we_o ? wdata_q : '0;

  assign rd_hit_cnt_o  = hit_cnt_q;
  assign rd_miss_cnt_o = miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_q     <= '0;
      resp_rd_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      resp_q     <= resp_d;
      resp_rd_q  <= resp_rd_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (line_we) begin
        valid_q[line_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && line_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= line_data;
    end
  end

endmodule
